// File: rtl/retire_trace_pkg.sv
// Shared widths, record layout and pairing-FSM encoding for the retire trace path.
package retire_trace_pkg;
  localparam int PC_W   = 32;
  localparam int PSR_W  = 32;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int REC_W  = PC_W + PSR_W + 1 + IDX_W + DATA_W;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PSR_W-1:0]  psr;
    logic              gpr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } trc_rec_t;
endpackage

// File: rtl/retire_trace_fifo.sv
// First-word-fall-through record FIFO; a push while full is taken only if a pop frees a slot.
module retire_trace_fifo #(
  parameter int REC_W = 102,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REC_W-1:0] push_data,
  input  logic             pop,
  output logic [REC_W-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [REC_W-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; the head is zero-gated while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/retire_trace_ctrl.sv
// Pairs retires with their GPR writeback (same or next cycle) and queues ordered trace records.
module retire_trace_ctrl
  import retire_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trc_en,
  input  logic              retire,
  input  logic [PC_W-1:0]   retire_pc,
  input  logic [PSR_W-1:0]  psr,
  input  logic              wb_gpr_en,
  input  logic [IDX_W-1:0]  wb_gpr_index,
  input  logic [DATA_W-1:0] wb_gpr_data,
  output logic              trc_vld,
  input  logic              trc_rdy,
  output logic [PC_W-1:0]   trc_pc,
  output logic [PSR_W-1:0]  trc_psr,
  output logic              trc_gpr_en,
  output logic [IDX_W-1:0]  trc_gpr_idx,
  output logic [DATA_W-1:0] trc_gpr_data,
  output logic [31:0]       retire_cnt,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [DROP_W-1:0] stray_cnt,
  output logic              ovf
);
  localparam logic [DROP_W-1:0] CNT_ONE = 1;

  state_e            state, state_nxt;
  logic [PC_W-1:0]   pend_pc;
  logic [PSR_W-1:0]  pend_psr;
  logic              latch, push, stray_inc, drop, empty, full;
  logic              acc_ret, acc_wb, wb_live;
  trc_rec_t          push_rec, head_rec;

  assign acc_ret = trc_en & retire;
  assign acc_wb  = trc_en & wb_gpr_en;
  // x0 writes carry no architectural effect, so they are recorded as no-write.
  assign wb_live = wb_gpr_en & (wb_gpr_index != '0);

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    push      = 1'b0;
    stray_inc = 1'b0;
    push_rec  = '0;
    push_rec.gpr_en = wb_live;
    push_rec.idx    = wb_live ? wb_gpr_index : '0;
    push_rec.data   = wb_live ? wb_gpr_data  : '0;
    case (state)
      IDLE: begin
        if (acc_ret && acc_wb) begin
          push         = 1'b1;
          push_rec.pc  = retire_pc;
          push_rec.psr = psr;
        end else if (acc_ret) begin
          latch     = 1'b1;
          state_nxt = PEND;
        end else if (acc_wb) begin
          stray_inc = 1'b1;
        end
      end
      PEND: begin
        // The held retire owns any writeback seen now, even with capture disabled.
        push         = 1'b1;
        push_rec.pc  = pend_pc;
        push_rec.psr = pend_psr;
        if (acc_ret) latch = 1'b1;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drop = push & full & ~(trc_vld & trc_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_pc    <= '0;
      pend_psr   <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      stray_cnt  <= '0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        pend_pc  <= retire_pc;
        pend_psr <= psr;
      end
      if (acc_ret) retire_cnt <= retire_cnt + 32'd1;
      if (drop) begin
        ovf <= 1'b1;
        if (~&drop_cnt) drop_cnt <= drop_cnt + CNT_ONE;
      end
      if (stray_inc && ~&stray_cnt) stray_cnt <= stray_cnt + CNT_ONE;
    end
  end

  retire_trace_fifo #(.REC_W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (trc_rdy),
    .head_data (head_rec),
    .empty     (empty),
    .full      (full)
  );

  assign trc_vld      = ~empty;
  assign trc_pc       = head_rec.pc;
  assign trc_psr      = head_rec.psr;
  assign trc_gpr_en   = head_rec.gpr_en;
  assign trc_gpr_idx  = head_rec.idx;
  assign trc_gpr_data = head_rec.data;
endmodule
